// File: rtl/internal_cell.sv
// -----------------------------------------------------------------------------
// internal_cell
//   Off-diagonal processing element of the triangularization systolic array.
//   It applies the row multiplier c and swap flag s (from the diagonal cell)
//   to its stored element p and the northern operand x, emits the eliminated
//   value south, and forwards c/s east. A drain request unloads p once the
//   multiply-add pipeline has emptied.
//
//   Data format: signed two's-complement Q(32-FRAC).FRAC.
//   Optional feature macro: SATURATE_EN. When it is defined, the product and
//   the final sum saturate on signed overflow; otherwise both wrap mod 2^32.
//
// Parameters:
//   MAC_LAT      cycles from the accepting edge to x_out (1..4)
//   FRAC         fractional bits of the data format
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   operation    1 = neighbouring pivoting, 0 = non-pivoting (s_in ignored)
//   in_valid     x_in / c_in / s_in valid this cycle
//   x_in         operand from the north
//   c_in         multiplier from the west
//   s_in         swap flag from the west
//   drain        single-cycle request to unload p
//   x_out        result to the south
//   x_out_valid  x_out valid
//   c_out        c_in delayed one cycle
//   s_out        effective swap flag delayed one cycle
//   cs_valid     in_valid delayed one cycle, qualifies c_out / s_out
//   busy         high while a drain is in progress
// -----------------------------------------------------------------------------
module internal_cell #(
    parameter int MAC_LAT = 2,
    parameter int FRAC    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        operation,
    input  logic        in_valid,
    input  logic [31:0] x_in,
    input  logic [31:0] c_in,
    input  logic        s_in,
    input  logic        drain,
    output logic [31:0] x_out,
    output logic        x_out_valid,
    output logic [31:0] c_out,
    output logic        s_out,
    output logic        cs_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DRAIN_WAIT = 2'd1,
        DRAIN_OUT  = 2'd2
    } state_t;

    // Fixed-point product: full 64-bit signed multiply, arithmetic shift by
    // FRAC (rounds toward -inf), then reduce to 32 bits.
    function automatic logic [31:0] scale_product(input logic [31:0] a,
                                                  input logic [31:0] b);
        logic signed [63:0] prod;
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`ifdef SATURATE_EN
        begin
            logic signed [63:0] sh;
            sh = prod >>> FRAC;
            if (sh > 64'sd2147483647) begin
                return 32'h7FFF_FFFF;
            end else if (sh < -64'sd2147483648) begin
                return 32'h8000_0000;
            end else begin
                return sh[31:0];
            end
        end
`else
        return 32'(prod >>> FRAC);
`endif
    endfunction

    // Final accumulate of product and addend.
    function automatic logic [31:0] add_fx(input logic [31:0] a,
                                           input logic [31:0] b);
`ifdef SATURATE_EN
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        // Sign bits disagree only on signed overflow.
        if (s[32] != s[31]) begin
            return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            return s[31:0];
        end
`else
        return a + b;
`endif
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] p_r;
    logic [31:0] prod_r;
    logic [31:0] addend_r;
    logic        v0_r;

    logic        se_s;
    logic        accept_s;
    logic        drain_out_s;
    logic [31:0] mult_b_s;
    logic [31:0] addend_s;
    logic [31:0] sum_s;
    logic [31:0] last_d_s;
    logic        last_v_s;
    logic        pipe_busy_s;

    assign se_s        = s_in & operation;
    assign accept_s    = in_valid & (state_r == RUN);
    assign drain_out_s = (state_r == DRAIN_OUT);
    // Operand routing uses p as held before this edge, so chained swaps work.
    assign mult_b_s    = se_s ? x_in : p_r;
    assign addend_s    = se_s ? p_r  : x_in;
    assign sum_s       = add_fx(prod_r, addend_r);

    // Next-state logic for the run / drain controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (drain) begin
                    state_next_s = DRAIN_WAIT;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN_WAIT: begin
                if (!pipe_busy_s) begin
                    state_next_s = DRAIN_OUT;
                end else begin
                    state_next_s = DRAIN_WAIT;
                end
            end
            DRAIN_OUT: state_next_s = RUN;
            default:   state_next_s = RUN;
        endcase
    end

    // Controller state register and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            busy    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s != RUN);
        end
    end

    // Stored element: loaded on an accepted swap, cleared when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r <= 32'h0000_0000;
        end else if (drain_out_s) begin
            p_r <= 32'h0000_0000;
        end else if (accept_s && se_s) begin
            p_r <= x_in;
        end
    end

    // First pipeline stage: scaled product and addend of an accepted input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_r     <= 1'b0;
            prod_r   <= 32'h0000_0000;
            addend_r <= 32'h0000_0000;
        end else begin
            v0_r <= accept_s;
            if (accept_s) begin
                prod_r   <= scale_product(c_in, mult_b_s);
                addend_r <= addend_s;
            end
        end
    end

    generate
        if (MAC_LAT == 1) begin : g_lat1
            assign last_d_s    = sum_s;
            assign last_v_s    = v0_r;
            assign pipe_busy_s = v0_r;
        end else begin : g_latn
            logic [31:0]        sum_pipe_r [MAC_LAT-1];
            logic [MAC_LAT-2:0] sv_r;

            // Delay line for sums so x_out lands exactly MAC_LAT cycles out.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sv_r <= '0;
                    for (int i = 0; i < MAC_LAT - 1; i++) begin
                        sum_pipe_r[i] <= 32'h0000_0000;
                    end
                end else begin
                    sv_r[0]       <= v0_r;
                    sum_pipe_r[0] <= sum_s;
                    for (int i = 1; i < MAC_LAT - 1; i++) begin
                        sv_r[i]       <= sv_r[i-1];
                        sum_pipe_r[i] <= sum_pipe_r[i-1];
                    end
                end
            end

            assign last_d_s    = sum_pipe_r[MAC_LAT-2];
            assign last_v_s    = sv_r[MAC_LAT-2];
            assign pipe_busy_s = v0_r | (|sv_r);
        end
    endgenerate

    // South output: pipeline result, or p during the drain cycle. The drain
    // cycle only follows an empty pipeline, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out       <= 32'h0000_0000;
            x_out_valid <= 1'b0;
        end else begin
            x_out_valid <= drain_out_s | last_v_s;
            if (drain_out_s) begin
                x_out <= p_r;
            end else if (last_v_s) begin
                x_out <= last_d_s;
            end
        end
    end

    // East forwarding, independent of the controller state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_out    <= 32'h0000_0000;
            s_out    <= 1'b0;
            cs_valid <= 1'b0;
        end else begin
            c_out    <= c_in;
            s_out    <= se_s;
            cs_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_internal_cell.sv
// -----------------------------------------------------------------------------
// tb_internal_cell
//   Directed self-checking bench for internal_cell (MAC_LAT = 2, FRAC = 16).
//   Expected values are hand-computed Q16.16 constants; the stored element p
//   is observed through drain cycles and through swaps that return the old p.
// -----------------------------------------------------------------------------
module tb_internal_cell;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        operation;
    logic        in_valid;
    logic [31:0] x_in;
    logic [31:0] c_in;
    logic        s_in;
    logic        drain;
    logic [31:0] x_out;
    logic        x_out_valid;
    logic [31:0] c_out;
    logic        s_out;
    logic        cs_valid;
    logic        busy;

    int n_cmp;
    int n_bad;

    logic        b2b_s [4];
    logic [31:0] b2b_c [4];
    logic [31:0] b2b_x [4];
    logic [31:0] b2b_e [4];
    logic        seen_valid;

    internal_cell #(.MAC_LAT(LAT), .FRAC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .operation   (operation),
        .in_valid    (in_valid),
        .x_in        (x_in),
        .c_in        (c_in),
        .s_in        (s_in),
        .drain       (drain),
        .x_out       (x_out),
        .x_out_valid (x_out_valid),
        .c_out       (c_out),
        .s_out       (s_out),
        .cs_valid    (cs_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic op, input logic s, input logic [31:0] c,
                         input logic [31:0] x);
        operation = op;
        s_in      = s;
        c_in      = c;
        x_in      = x;
        in_valid  = 1'b1;
    endtask

    // One isolated transaction: forwarding after 1 cycle, result after LAT.
    task automatic send_check(input string tag, input logic op, input logic s,
                              input logic [31:0] c, input logic [31:0] x,
                              input logic exp_se, input logic [31:0] exp);
        drive(op, s, c, x);
        tick();
        in_valid = 1'b0;
        check_value({tag, "_cs_valid"}, {31'd0, cs_valid}, 32'd1);
        check_value({tag, "_c_out"}, c_out, c);
        check_value({tag, "_s_out"}, {31'd0, s_out}, {31'd0, exp_se});
        for (int i = 0; i < LAT - 1; i++) begin
            tick();
            check_value({tag, "_early_valid"}, {31'd0, x_out_valid}, 32'd0);
        end
        tick();
        check_value({tag, "_valid"}, {31'd0, x_out_valid}, 32'd1);
        check_value({tag, "_x_out"}, x_out, exp);
    endtask

    // Drain with an empty pipeline; the unloaded value is the stored p.
    task automatic drain_check(input string tag, input logic [31:0] exp_p);
        drain = 1'b1;
        tick();
        drain = 1'b0;
        check_value({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8 && !x_out_valid; i++) begin
            tick();
        end
        check_value({tag, "_drain_valid"}, {31'd0, x_out_valid}, 32'd1);
        check_value({tag, "_drain_p"}, x_out, exp_p);
        check_value({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
        tick();
        check_value({tag, "_one_cycle"}, {31'd0, x_out_valid}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        b2b_s = '{1'b1, 1'b0, 1'b1, 1'b0};
        b2b_c = '{32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000};
        b2b_x = '{32'h0003_0000, 32'h0001_0000, 32'h0005_0000, 32'hFFFF_0000};
        b2b_e = '{32'h0003_0000, 32'h0007_0000, 32'hFFFE_0000, 32'h0001_8000};

        rst       = 1'b1;
        operation = 1'b0;
        in_valid  = 1'b0;
        x_in      = 32'd0;
        c_in      = 32'd0;
        s_in      = 1'b0;
        drain     = 1'b0;
        #12;
        check_value("rst_x_out", x_out, 32'd0);
        check_value("rst_x_out_valid", {31'd0, x_out_valid}, 32'd0);
        check_value("rst_c_out", c_out, 32'd0);
        check_value("rst_s_out", {31'd0, s_out}, 32'd0);
        check_value("rst_cs_valid", {31'd0, cs_valid}, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: preload p = 2.0, then non-pivot eliminate 3.0 + (-1.5 * 2.0) = 0
        send_check("t1_load", 1'b1, 1'b1, 32'h0000_0000, 32'h0002_0000, 1'b1, 32'h0000_0000);
        send_check("t1_elim", 1'b1, 1'b0, 32'hFFFE_8000, 32'h0003_0000, 1'b0, 32'h0000_0000);
        drain_check("t1", 32'h0002_0000);

        // 2: p = 1.0, swap: 1.0 + (-0.5 * 4.0) = -1.0, p <= 4.0
        send_check("t2_load", 1'b1, 1'b1, 32'h0000_0000, 32'h0001_0000, 1'b1, 32'h0000_0000);
        send_check("t2_swap", 1'b1, 1'b1, 32'hFFFF_8000, 32'h0004_0000, 1'b1, 32'hFFFF_0000);

        // 3: reload returns old p (4.0); operation=0 masks s_in: 1 + 1*1 = 2
        send_check("t3_load", 1'b1, 1'b1, 32'h0000_0000, 32'h0001_0000, 1'b1, 32'h0004_0000);
        send_check("t3_nopiv", 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0002_0000);
        drain_check("t3", 32'h0001_0000);

        // 4: four back-to-back inputs alternating swap / eliminate, p chained
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, b2b_s[i], b2b_c[i], b2b_x[i]);
            tick();
            check_value("t4_c_out", c_out, b2b_c[i]);
            check_value("t4_cs_valid", {31'd0, cs_valid}, 32'd1);
            if (i == 1) begin
                check_value("t4_not_yet", {31'd0, x_out_valid}, 32'd0);
            end else if (i >= 2) begin
                check_value("t4_valid", {31'd0, x_out_valid}, 32'd1);
                check_value("t4_x_out", x_out, b2b_e[i-2]);
            end else begin
                check_value("t4_idle", {31'd0, x_out_valid}, 32'd0);
            end
        end
        in_valid = 1'b0;
        for (int i = 2; i < 4; i++) begin
            tick();
            check_value("t4_valid", {31'd0, x_out_valid}, 32'd1);
            check_value("t4_x_out", x_out, b2b_e[i]);
        end
        check_value("t4_cs_drop", {31'd0, cs_valid}, 32'd0);
        drain_check("t4", 32'h0005_0000);

        // 5: drain with two results in flight; inputs and drain during busy ignored
        send_check("t5_load", 1'b1, 1'b1, 32'h0000_0000, 32'h0003_0000, 1'b1, 32'h0000_0000);
        drive(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        tick();
        drive(1'b1, 1'b0, 32'h0002_0000, 32'h0000_0000);
        drain = 1'b1;
        tick();
        check_value("t5_busy", {31'd0, busy}, 32'd1);
        drive(1'b1, 1'b1, 32'h0001_0000, 32'h0009_0000);
        tick();
        drain = 1'b0;
        check_value("t5_a_valid", {31'd0, x_out_valid}, 32'd1);
        check_value("t5_a", x_out, 32'h0004_0000);
        tick();
        check_value("t5_b_valid", {31'd0, x_out_valid}, 32'd1);
        check_value("t5_b", x_out, 32'h0006_0000);
        check_value("t5_busy_mid", {31'd0, busy}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_value("t5_ignored", {31'd0, x_out_valid}, 32'd0);
        for (int i = 0; i < 8 && !x_out_valid; i++) begin
            tick();
        end
        check_value("t5_drain_valid", {31'd0, x_out_valid}, 32'd1);
        check_value("t5_drain_p", x_out, 32'h0003_0000);
        check_value("t5_busy_lo", {31'd0, busy}, 32'd0);
        tick();
        send_check("t5_p_zero", 1'b1, 1'b1, 32'h0000_0000, 32'h0001_0000, 1'b1, 32'h0000_0000);

        // 6: overflow 2.0 + 1.0 * 32767.0, then reset mid-pipeline
        send_check("t6_load", 1'b1, 1'b1, 32'h0000_0000, 32'h7FFF_0000, 1'b1, 32'h0001_0000);
`ifdef SATURATE_EN
        send_check("t6_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0002_0000, 1'b0, 32'h7FFF_FFFF);
`else
        send_check("t6_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0002_0000, 1'b0, 32'h8001_0000);
`endif
        drive(1'b1, 1'b1, 32'h0005_0000, 32'h0001_0000);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_value("t6_rst_x_out", x_out, 32'd0);
        check_value("t6_rst_valid", {31'd0, x_out_valid}, 32'd0);
        check_value("t6_rst_c_out", c_out, 32'd0);
        check_value("t6_rst_s_out", {31'd0, s_out}, 32'd0);
        check_value("t6_rst_cs_valid", {31'd0, cs_valid}, 32'd0);
        check_value("t6_rst_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_valid = seen_valid | x_out_valid;
        end
        check_value("t6_no_result", {31'd0, seen_valid}, 32'd0);
        drain_check("t6_rst_p", 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/internal_cell.md
Name: internal_cell

Overview:
- Processing element for the non-diagonal positions of the triangularization systolic array.
- Consumes the multiplier `c` and swap flag `s` produced by the diagonal cell of its row and applies them to its own stored element `p` and the incoming operand `x`.
- Emits the eliminated value south and forwards `c`/`s` east to the next internal cell.
- Adds a pipelined fixed-point multiply-add, valid tracking, and a drain mode that unloads the stored element.

Parameters:
- MAC_LAT, 2, pipeline depth (cycles) from accepted input to `x_out`; legal range 1..4.
- FRAC, 16, fractional bits of the signed two's-complement Q(32-FRAC).FRAC data format.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- operation  in  1  1 = neighbouring-pivoting mode; 0 = non-pivoting mode (`s_in` treated as 0).
- in_valid  in  1  `x_in`, `c_in` and `s_in` are valid this cycle.
- x_in  in  32  operand from the north.
- c_in  in  32  multiplier from the west.
- s_in  in  1  swap flag from the west.
- drain  in  1  single-cycle pulse requesting unload of `p`.
- x_out  out  32  result to the south.
- x_out_valid  out  1  `x_out` valid.
- c_out  out  32  `c_in` delayed 1 cycle.
- s_out  out  1  effective swap flag delayed 1 cycle.
- cs_valid  out  1  `in_valid` delayed 1 cycle, qualifies `c_out`/`s_out`.
- busy  out  1  high in DRAIN_WAIT and DRAIN_OUT.

Behaviour:
- Reset: `p`, `x_out`, `c_out` = 0; `x_out_valid`, `s_out`, `cs_valid`, `busy` = 0; FSM = RUN; all pipeline valid bits cleared. Reset mid-operation discards in-flight results.
- Effective swap: `se = s_in & operation`.
- An input is accepted when `in_valid` is high and the FSM is in RUN. When accepted:
  - se=0: result = x_in + c_in*p; `p` unchanged.
  - se=1: result = p + c_in*x_in; `p` <= x_in at the same edge.
  - Operand selection uses `p` as held before that edge, so back-to-back swaps chain correctly.
- Arithmetic:
  - Product is full 64-bit signed, arithmetic-shifted right by FRAC (truncation toward -inf), low 32 bits kept.
  - The sum wraps mod 2^32, unless SATURATE_EN is defined.
- Latency:
  - `x_out` / `x_out_valid` appear exactly MAC_LAT cycles after the accepting edge.
  - Full throughput: one result per cycle.
- Forwarding: `c_out`, `s_out` (= se) and `cs_valid` are registered from the inputs every cycle, independent of the FSM. `cs_valid` follows `in_valid` even when the input is not accepted.
- Initial pivot: `p` = 0 after reset, so the first swap with c=0 yields `x_out` = 0 and loads `p`; no special case.
- FSM:
  - RUN: on `drain`, go to DRAIN_WAIT. An `in_valid` in the same cycle as `drain` is still accepted.
  - DRAIN_WAIT: `in_valid` is ignored (not accepted, no `p` change); stay until no pipeline stage holds a valid result, then go to DRAIN_OUT.
  - DRAIN_OUT: one cycle; `x_out` = p, `x_out_valid` = 1, `p` <= 0; go to RUN.
  - `drain` asserted while `busy` is ignored.
- The drain output never collides with a pipeline result, because the pipeline is empty first.

Optional Feature:
- Macro: SATURATE_EN.
- Defined: the final add saturates to 0x7FFFFFFF / 0x80000000 on signed overflow. The product is also clamped to the 32-bit range before the add if its shifted value overflows.
- Undefined: two's-complement wrap for both the product and the sum.

Test Plan:
1. Non-pivot eliminate, MAC_LAT=2:
   - Stimulus: preload p=2.0 (0x00020000) via a swap with c=0, x=2.0; then operation=1, s=0, c=-1.5 (0xFFFE8000), x=3.0 (0x00030000).
   - Required: `x_out` = 0 exactly 2 cycles later; p stays 0x00020000.
2. Swap:
   - Stimulus: p=1.0, s=1, c=-0.5, x=4.0.
   - Required: `x_out` = 1.0 + (-0.5*4.0) = -1.0 (0xFFFF0000); p becomes 0x00040000.
3. operation=0 with s_in=1, p=1.0, x=1.0, c=1.0:
   - Required: `x_out` = 2.0; p unchanged; `s_out` = 0 on the next cycle.
4. Back-to-back:
   - Stimulus: 4 consecutive valid inputs alternating s=1/0 (operation=1).
   - Required: 4 consecutive `x_out_valid` cycles, each value matching a reference model using the chained `p`; `c_out` equals `c_in` delayed by 1.
5. Drain with 2 results in flight:
   - Required: `busy` = 1; `in_valid` during `busy` is ignored; after the last result, one cycle with `x_out` = p; p = 0 afterwards; `busy` drops.
6. Overflow and reset:
   - Stimulus: p=0x7FFF0000, c=1.0, x=0x00020000, s=0.
   - Required: `x_out` = 0x7FFFFFFF with SATURATE_EN, 0x80010000 without.
   - Then assert `rst` mid-pipeline: all outputs 0 immediately and no `x_out_valid` afterwards.
